// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one digit per clock, signed/unsigned per operation, valid/ready on both sides.
// Optional macro BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier digits are all zero.
module booth_r4_seq_mult #(
    parameter int unsigned N = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           signed_mode,
    input  logic [N-1:0]   md,
    input  logic [N-1:0]   mr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int unsigned D  = N / 2 + 1;
    localparam int unsigned AW = 2 * N + 2;
    localparam int unsigned MW = N + 2;
    localparam int unsigned RW = N + 3;
    localparam int unsigned CW = $clog2(D + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [MW-1:0]   md_q;
    logic [RW-1:0]   mr_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [2*N-1:0]  product_q;

    logic [AW-1:0]   md_wide;
    logic [AW-1:0]   mag;
    logic            neg;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   acc_d;
    logic [RW-1:0]   mr_d;
    logic            last_digit;
    logic [1:0]      ext;

    assign ext = signed_mode ? {2{mr[N-1]}} : 2'b00;

    // Booth digit decode and weighted partial product for the current digit
    always_comb begin
        mag     = '0;
        neg     = 1'b0;
        md_wide = {{(AW - MW){md_q[MW-1]}}, md_q};
        case (mr_q[2:0])
            3'b001, 3'b010: mag = md_wide;
            3'b011:         mag = md_wide << 1;
            3'b100: begin
                mag = md_wide << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = md_wide;
                neg = 1'b1;
            end
            default:        mag = '0;
        endcase
        addend = neg ? (~mag + AW'(1)) : mag;
        acc_d  = acc_q + (addend << {cnt_q, 1'b0});
        mr_d   = RW'($signed(mr_q) >>> 2);
`ifdef BOOTH_EARLY_TERM_EN
        // Remaining multiplier all-0 or all-1 means every later digit is zero
        last_digit = (cnt_q == CW'(D - 1)) || (mr_d == '0) || (&mr_d);
`else
        last_digit = (cnt_q == CW'(D - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            md_q        <= '0;
            mr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        md_q       <= signed_mode ? {{2{md[N-1]}}, md} : {2'b00, md};
                        mr_q       <= {ext, mr, 1'b0};
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    mr_q  <= mr_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_digit) begin
                        product_q   <= acc_d[2*N-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule
